booth_op_sequencer: RTL and testbench

BOOTH_OP_SEQUENCER -- requirements
Module: booth_op_sequencer

---
 rtl/booth_op_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_booth_op_sequencer.sv | 555 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_op_sequencer.sv
// Booth operation sequencer: queues signed 16-bit operand pairs in a 2-entry FIFO,
// feeds each pair to a serial Booth multiplier core over a shared operand bus,
// waits (with timeout) for the core to finish and hands the product downstream.
module booth_op_sequencer #(
    parameter int unsigned TIMEOUT = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        mul_start,
    output logic [15:0] mul_data,
    input  logic        mul_done,
    input  logic [31:0] mul_result,
    output logic        mul_restart,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_product,
    output logic        out_err
);

    // Counter only has to reach TIMEOUT-1.
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StLdM,
        StLdQ,
        StWait,
        StOut,
        StRestart
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     a_q, a_d;
    logic [15:0]     b_q, b_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     product_q, product_d;
    logic            err_q, err_d;

    // Operand FIFO: each entry is {a, b}.
    logic [31:0] fifo_mem_q [2];
    logic        wr_ptr_q;
    logic        rd_ptr_q;
    logic [1:0]  count_q;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;

    assign fifo_full  = (count_q == 2'd2);
    assign fifo_empty = (count_q == 2'd0);
    assign in_ready   = !fifo_full && !rst;
    assign push       = in_valid && in_ready;
    // Pops are decided on the registered count, so a pair pushed this cycle waits one cycle.
    assign pop        = (state_q == StIdle) && !fifo_empty;

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {in_a, in_b};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sequencer state and job datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic: operand load, core handshake, timeout and result capture.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        err_d     = err_q;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    {a_d, b_d} = fifo_mem_q[rd_ptr_q];
                    state_d    = StStart;
                end
            end
            StStart: state_d = StLdM;
            StLdM:   state_d = StLdQ;
            StLdQ: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                // A done flag on the last allowed cycle still counts as a valid result.
                if (mul_done) begin
                    product_d = mul_result;
                    err_d     = 1'b0;
                    state_d   = StOut;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    product_d = '0;
                    err_d     = 1'b1;
                    state_d   = StOut;
                end
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StRestart;
                end
            end
            StRestart: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Core-facing and downstream outputs; reset overrides them immediately.
    always_comb begin
        mul_start   = 1'b0;
        mul_data    = '0;
        mul_restart = 1'b0;
        out_valid   = 1'b0;
        unique case (state_q)
            StStart: begin
                mul_start = 1'b1;
                mul_data  = a_q;
            end
            StLdM:     mul_data    = a_q;
            StLdQ:     mul_data    = b_q;
            StOut:     out_valid   = 1'b1;
            StRestart: mul_restart = 1'b1;
            default:   ;
        endcase
        if (rst) begin
            mul_start   = 1'b0;
            mul_data    = '0;
            out_valid   = 1'b0;
            mul_restart = 1'b1;
        end
    end

    assign out_product = rst ? 32'd0 : product_q;
    assign out_err     = !rst && err_q;

endmodule

// File: tb/tb_booth_op_sequencer.sv
// Self-checking bench for booth_op_sequencer with a behavioural serial-core model.
module tb_booth_op_sequencer;

    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        mul_start;
    logic [15:0] mul_data;
    logic        mul_done = 1'b0;
    logic [31:0] mul_result = '0;
    logic        mul_restart;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_product;
    logic        out_err;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] product;
        logic        err;
    } exp_t;

    typedef struct packed {
        logic [15:0] d0;
        logic [15:0] d1;
        logic [15:0] d2;
    } ld_t;

    exp_t exp_q[$];
    ld_t  ld_q[$];

    // Core model configuration.
    bit core_hang = 1'b0;
    int core_latency = 0;

    booth_op_sequencer #(
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .mul_start  (mul_start),
        .mul_data   (mul_data),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .mul_restart(mul_restart),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_product(out_product),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    // Serial core model: start pulse, multiplicand next cycle, multiplier the cycle after,
    // then done after core_latency further cycles (never when hung).
    int          core_phase = 0;
    int          core_cnt = 0;
    int          core_pa = 0;
    int          core_pb = 0;
    logic [15:0] core_d0 = '0;
    logic [15:0] core_m = '0;
    always begin
        @(posedge clk);
        #2;
        if (rst || mul_restart) begin
            core_phase = 0;
            mul_done   = 1'b0;
        end else begin
            case (core_phase)
                0: if (mul_start) begin
                    core_d0    = mul_data;
                    core_phase = 1;
                end
                1: begin
                    core_m     = mul_data;
                    core_phase = 2;
                end
                2: begin
                    ld_q.push_back(ld_t'({core_d0, core_m, mul_data}));
                    core_pa    = $signed(core_m);
                    core_pb    = $signed(mul_data);
                    core_cnt   = core_latency;
                    core_phase = 3;
                end
                3: if (!core_hang) begin
                    if (core_cnt == 0) begin
                        mul_result = 32'(core_pa * core_pb);
                        mul_done   = 1'b1;
                        core_phase = 4;
                    end else begin
                        core_cnt--;
                    end
                end
                default: ;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    // Expected outcome of one job: core answers in wait cycle core_latency+1, the
    // sequencer gives up after TIMEOUT wait cycles.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        int   pa;
        int   pb;
        exp_t e;
        pa = $signed(a);
        pb = $signed(b);
        e.err = core_hang || (core_latency >= int'(TIMEOUT));
        e.product = e.err ? 32'd0 : 32'(pa * pb);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a pair until accepted; returns one cycle after the accepting cycle.
    task automatic push(input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        vectors++;
        if (!in_ready) begin
            miscompares++;
            $display("FAIL push_accept: in_ready=%0b required 1", in_ready);
        end else begin
            exp_q.push_back(model(a, b));
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int budget, output int cycles, output bit ok);
        cycles = 0;
        while (!out_valid && cycles < budget) begin
            tick();
            cycles++;
        end
        ok = out_valid;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({in_ready, mul_restart, out_valid, mul_start, out_err} !== 5'b01000) begin
            miscompares++;
            $display("FAIL reset_ctrl: {in_ready,mul_restart,out_valid,mul_start,out_err}=%b required 01000",
                     {in_ready, mul_restart, out_valid, mul_start, out_err});
        end
        vectors++;
        if (mul_data !== 16'd0 || out_product !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_data: mul_data=%h out_product=%h required 0", mul_data, out_product);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || mul_restart !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: in_ready=%b mul_restart=%b required 1 0", in_ready, mul_restart);
        end
        exp_q.delete();
        ld_q.delete();
    endtask

    task automatic test_basic();
        int   n;
        bit   ok;
        exp_t e;
        ld_t  l;
        core_hang = 1'b0;
        core_latency = 4;
        push(16'd3, 16'd5);
        vectors++;
        if (mul_start !== 1'b0) begin
            miscompares++;
            $display("FAIL start_early: mul_start=%b at C+1 required 0", mul_start);
        end
        tick();
        vectors++;
        if (mul_start !== 1'b1 || mul_data !== 16'd3) begin
            miscompares++;
            $display("FAIL start_c2: mul_start=%b mul_data=%0d required 1 3", mul_start, mul_data);
        end
        tick();
        vectors++;
        if (mul_start !== 1'b0 || mul_data !== 16'd3) begin
            miscompares++;
            $display("FAIL ld_m: mul_start=%b mul_data=%0d required 0 3", mul_start, mul_data);
        end
        tick();
        vectors++;
        if (mul_data !== 16'd5) begin
            miscompares++;
            $display("FAIL ld_q: mul_data=%0d required 5", mul_data);
        end
        tick();
        vectors++;
        if (mul_data !== 16'd0) begin
            miscompares++;
            $display("FAIL wait_bus: mul_data=%0d required 0", mul_data);
        end
        wait_out(TIMEOUT + 20, n, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL basic_out: out_valid=%b required 1", out_valid);
        end else if (out_product !== 32'h0000000F || out_err !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_product: got %h err %b required 0000000f err 0", out_product, out_err);
        end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        if (ld_q.size() > 0) l = ld_q.pop_front();
        accept();
        vectors++;
        if (mul_restart !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_restart: mul_restart=%b out_valid=%b required 1 0", mul_restart, out_valid);
        end
        tick();
        vectors++;
        if (mul_restart !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_restart_len: mul_restart=%b required 0", mul_restart);
        end
    endtask

    task automatic test_products();
        logic [15:0] av [8];
        logic [15:0] bv [8];
        logic [31:0] want [2];
        int          n;
        bit          ok;
        exp_t        e;
        ld_t         l;
        av[0] = 16'hFFF9; bv[0] = 16'd6;
        av[1] = 16'h8000; bv[1] = 16'h8000;
        want[0] = 32'hFFFFFFD6;
        want[1] = 32'h40000000;
        for (int i = 2; i < 8; i++) begin
            av[i] = 16'($urandom);
            bv[i] = 16'($urandom);
        end
        core_hang = 1'b0;
        for (int i = 0; i < 8; i++) begin
            core_latency = int'($urandom_range(0, 8));
            push(av[i], bv[i]);
            wait_out(TIMEOUT + 20, n, ok);
            vectors++;
            if (!ok || exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL prod_out[%0d]: out_valid=%b required 1", i, out_valid);
            end else begin
                e = exp_q.pop_front();
                if (out_product !== e.product || out_err !== e.err) begin
                    miscompares++;
                    $display("FAIL prod[%0d]: %h*%h got %h err %b required %h err %b",
                             i, av[i], bv[i], out_product, out_err, e.product, e.err);
                end
                if (i < 2) begin
                    vectors++;
                    if (out_product !== want[i]) begin
                        miscompares++;
                        $display("FAIL prod_const[%0d]: got %h required %h", i, out_product, want[i]);
                    end
                end
            end
            vectors++;
            if (ld_q.size() == 0) begin
                miscompares++;
                $display("FAIL prod_bus[%0d]: no operand load seen, required 1", i);
            end else begin
                l = ld_q.pop_front();
                if (l !== ld_t'({av[i], av[i], bv[i]})) begin
                    miscompares++;
                    $display("FAIL prod_bus[%0d]: got %h required %h", i, l,
                             ld_t'({av[i], av[i], bv[i]}));
                end
            end
            accept();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] av [4];
        logic [15:0] bv [4];
        int          got = 0;
        for (int i = 0; i < 4; i++) begin
            av[i] = 16'($urandom);
            bv[i] = 16'($urandom);
        end
        core_hang = 1'b0;
        core_latency = 6;
        push(av[0], bv[0]);
        tick();
        in_valid = 1'b1;
        for (int i = 1; i < 3; i++) begin
            in_a = av[i];
            in_b = bv[i];
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_ready[%0d]: in_ready=%b required 1", i, in_ready);
            end
            tick();
            exp_q.push_back(model(av[i], bv[i]));
        end
        in_a = av[3];
        in_b = bv[3];
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_full: in_ready=%b on third push required 0", in_ready);
        end
        fork
            begin
                int n = 0;
                while (!in_ready && n < 300) begin
                    tick();
                    n++;
                end
                vectors++;
                if (!in_ready || got != 1) begin
                    miscompares++;
                    $display("FAIL b2b_third: in_ready=%b results_before=%0d required 1 1",
                             in_ready, got);
                end
                exp_q.push_back(model(av[3], bv[3]));
                tick();
                in_valid = 1'b0;
            end
            begin
                int   n;
                bit   ok;
                exp_t e;
                ld_t  l;
                for (int k = 0; k < 4; k++) begin
                    wait_out(TIMEOUT + 40, n, ok);
                    vectors++;
                    if (!ok || exp_q.size() == 0 || ld_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL b2b_out[%0d]: out_valid=%b required 1", k, out_valid);
                    end else begin
                        e = exp_q.pop_front();
                        l = ld_q.pop_front();
                        if (out_product !== e.product || out_err !== e.err ||
                            l !== ld_t'({av[k], av[k], bv[k]})) begin
                            miscompares++;
                            $display("FAIL b2b_order[%0d]: got %h err %b bus %h required %h err %b bus %h",
                                     k, out_product, out_err, l, e.product, e.err,
                                     ld_t'({av[k], av[k], bv[k]}));
                        end
                    end
                    accept();
                    got++;
                end
            end
        join
    endtask

    task automatic test_timeout();
        int   n;
        bit   ok;
        exp_t e;
        core_hang = 1'b1;
        push(16'($urandom), 16'($urandom));
        tick();
        vectors++;
        if (mul_start !== 1'b1) begin
            miscompares++;
            $display("FAIL to_start: mul_start=%b required 1", mul_start);
        end
        wait_out(TIMEOUT + 40, n, ok);
        vectors++;
        if (!ok || n != int'(TIMEOUT) + 3) begin
            miscompares++;
            $display("FAIL to_cycles: out after %0d cycles from start required %0d", n, TIMEOUT + 3);
        end
        vectors++;
        if (out_product !== 32'd0 || out_err !== 1'b1) begin
            miscompares++;
            $display("FAIL to_result: got %h err %b required 00000000 err 1", out_product, out_err);
        end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        void'(ld_q.pop_front());
        accept();
        vectors++;
        if (mul_restart !== 1'b1) begin
            miscompares++;
            $display("FAIL to_restart: mul_restart=%b required 1", mul_restart);
        end
        tick();
        core_hang = 1'b0;
        // Done on the last allowed wait cycle wins; one cycle later is too late.
        for (int k = 0; k < 2; k++) begin
            core_latency = int'(TIMEOUT) - 1 + k;
            push(16'($urandom_range(1, 30000)), 16'($urandom_range(1, 30000)));
            tick();
            wait_out(TIMEOUT + 40, n, ok);
            vectors++;
            if (!ok || n != int'(TIMEOUT) + 3 || exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL edge_cycles[%0d]: out after %0d cycles required %0d", k, n, TIMEOUT + 3);
            end else begin
                e = exp_q.pop_front();
                if (out_product !== e.product || out_err !== e.err) begin
                    miscompares++;
                    $display("FAIL edge_result[%0d]: got %h err %b required %h err %b",
                             k, out_product, out_err, e.product, e.err);
                end
            end
            void'(ld_q.pop_front());
            accept();
            tick();
        end
    endtask

    task automatic test_stall();
        int   n;
        bit   ok;
        exp_t e;
        core_hang = 1'b0;
        core_latency = 2;
        push(16'($urandom), 16'($urandom));
        wait_out(TIMEOUT + 20, n, ok);
        vectors++;
        if (!ok || exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL stall_out: out_valid=%b required 1", out_valid);
            e = '0;
        end else begin
            e = exp_q.pop_front();
        end
        void'(ld_q.pop_front());
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_product !== e.product || out_err !== e.err ||
                mul_restart !== 1'b0) begin
                miscompares++;
                $display("FAIL stall[%0d]: valid=%b prod=%h err=%b restart=%b required 1 %h %b 0",
                         i, out_valid, out_product, out_err, mul_restart, e.product, e.err);
            end
        end
        accept();
        vectors++;
        if (mul_restart !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_restart: mul_restart=%b out_valid=%b required 1 0", mul_restart, out_valid);
        end
        tick();
    endtask

    task automatic test_reset_midjob();
        int   n;
        bit   ok;
        int   bad = 0;
        exp_t e;
        core_hang = 1'b1;
        push(16'($urandom), 16'($urandom));
        push(16'($urandom), 16'($urandom));
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        vectors++;
        if (mul_restart !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_during: restart=%b in_ready=%b out_valid=%b required 1 0 0",
                     mul_restart, in_ready, out_valid);
        end
        tick();
        rst = 1'b0;
        #1;
        exp_q.delete();
        ld_q.delete();
        vectors++;
        if (in_ready !== 1'b1 || mul_restart !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_release: in_ready=%b restart=%b required 1 0", in_ready, mul_restart);
        end
        for (int i = 0; i < 3 * int'(TIMEOUT); i++) begin
            if (mul_start || out_valid || mul_data != 16'd0) bad++;
            tick();
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL midrst_quiet: %0d active cycles after reset required 0", bad);
        end
        core_hang = 1'b0;
        core_latency = 3;
        push(16'($urandom), 16'($urandom));
        wait_out(TIMEOUT + 20, n, ok);
        vectors++;
        if (!ok || exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL midrst_next: out_valid=%b required 1", out_valid);
        end else begin
            e = exp_q.pop_front();
            if (out_product !== e.product || out_err !== e.err) begin
                miscompares++;
                $display("FAIL midrst_next_result: got %h err %b required %h err %b",
                         out_product, out_err, e.product, e.err);
            end
        end
        accept();
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_products();
        test_back_to_back();
        test_timeout();
        test_stall();
        test_reset_midjob();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
